latch_exerciser: RTL and testbench

LATCH_EXERCISER -- requirements
Module: latch_exerciser

---
 rtl/latch_exerciser.sv | 222 ++++++++++++++++++++++
 tb/tb_latch_exerciser.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/latch_exerciser.sv
// latch_exerciser: drives a fixed six-step C/D stimulus into a gated D latch,
// holds each step for SETTLE clocks, samples Q/notQ at the end of each step
// and reports the per-step mismatches (fail_mask) and an overall pass flag.
module latch_exerciser #(
  parameter int SETTLE = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       q_in,
  input  logic       notq_in,
  output logic       c_out,
  output logic       d_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] fail_mask,
  output logic [2:0] step_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter value on which the current step is sampled and the next step begins.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [2:0] LAST_STEP   = 3'd5;

  // Stimulus table: C input for each step.
  function automatic logic step_c(input logic [2:0] idx);
    case (idx)
      3'd0:    step_c = 1'b1;
      3'd1:    step_c = 1'b0;
      3'd2:    step_c = 1'b1;
      3'd3:    step_c = 1'b0;
      3'd4:    step_c = 1'b1;
      default: step_c = 1'b0;
    endcase
  endfunction

  // Stimulus table: D input for each step.
  function automatic logic step_d(input logic [2:0] idx);
    case (idx)
      3'd0:    step_d = 1'b0;
      3'd1:    step_d = 1'b1;
      3'd2:    step_d = 1'b1;
      3'd3:    step_d = 1'b0;
      3'd4:    step_d = 1'b0;
      default: step_d = 1'b0;
    endcase
  endfunction

  // Stimulus table: Q the latch must show at the end of each step.
  // Steps 1, 3 and 5 have C low, so they test that the latch holds.
  function automatic logic step_q(input logic [2:0] idx);
    case (idx)
      3'd0:    step_q = 1'b0;
      3'd1:    step_q = 1'b0;
      3'd2:    step_q = 1'b1;
      3'd3:    step_q = 1'b1;
      3'd4:    step_q = 1'b0;
      default: step_q = 1'b0;
    endcase
  endfunction

  // Registered state and outputs.
  state_t     r_state;
  logic [3:0] r_settle;
  logic [2:0] r_step;
  logic       r_c;
  logic       r_d;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [5:0] r_mask;

  // Next-state values produced by the combinational FSM.
  state_t     w_state_next;
  logic [3:0] w_settle_next;
  logic [2:0] w_step_next;
  logic       w_c_next;
  logic       w_d_next;
  logic       w_busy_next;
  logic       w_done_next;
  logic       w_pass_next;
  logic [5:0] w_mask_next;

  // Sampling helpers.
  logic       w_exp_q;
  logic       w_mismatch;
  logic       w_sample;
  logic [2:0] w_step_inc;
  logic [5:0] w_step_bit;
  logic [5:0] w_mask_upd;

  // Compare Q/notQ against the current step's expectation; only used on sample edges.
  always_comb begin
    w_exp_q    = step_q(r_step);
    w_mismatch = (q_in != w_exp_q) || (notq_in != ~w_exp_q);
    w_sample   = (r_settle == SETTLE_LAST);
    w_step_inc = r_step + 3'd1;
    w_step_bit = 6'(6'd1 << r_step);
    if (w_mismatch) begin
      w_mask_upd = r_mask | w_step_bit;
    end else begin
      w_mask_upd = r_mask;
    end
  end

  // Next-state and next-output logic for IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    w_state_next  = r_state;
    w_settle_next = r_settle;
    w_step_next   = r_step;
    w_c_next      = r_c;
    w_d_next      = r_d;
    w_busy_next   = r_busy;
    w_done_next   = 1'b0;
    w_pass_next   = r_pass;
    w_mask_next   = r_mask;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          // Accept a run: results of the previous run are discarded here.
          w_state_next  = ST_RUN;
          w_settle_next = 4'd0;
          w_step_next   = 3'd0;
          w_c_next      = step_c(3'd0);
          w_d_next      = step_d(3'd0);
          w_busy_next   = 1'b1;
          w_pass_next   = 1'b0;
          w_mask_next   = 6'd0;
        end else begin
          w_state_next = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (w_sample) begin
          w_mask_next   = w_mask_upd;
          w_settle_next = 4'd0;
          if (r_step == LAST_STEP) begin
            // Final sample: pass must include this step's result.
            w_state_next = ST_DONE;
            w_step_next  = 3'd0;
            w_c_next     = 1'b0;
            w_d_next     = 1'b0;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
            w_pass_next  = (w_mask_upd == 6'd0);
          end else begin
            w_step_next = w_step_inc;
            w_c_next    = step_c(w_step_inc);
            w_d_next    = step_d(w_step_inc);
          end
        end else begin
          w_settle_next = r_settle + 4'd1;
        end
      end

      ST_DONE: begin
        // One cycle here keeps a held start from retriggering on the done edge.
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next  = ST_IDLE;
        w_settle_next = 4'd0;
        w_step_next   = 3'd0;
        w_c_next      = 1'b0;
        w_d_next      = 1'b0;
        w_busy_next   = 1'b0;
        w_pass_next   = 1'b0;
        w_mask_next   = 6'd0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath and output registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle <= 4'd0;
      r_step   <= 3'd0;
      r_c      <= 1'b0;
      r_d      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_mask   <= 6'd0;
    end else begin
      r_settle <= w_settle_next;
      r_step   <= w_step_next;
      r_c      <= w_c_next;
      r_d      <= w_d_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
      r_pass   <= w_pass_next;
      r_mask   <= w_mask_next;
    end
  end

  assign c_out     = r_c;
  assign d_out     = r_d;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_mask = r_mask;
  assign step_idx  = r_step;

endmodule

// File: tb/tb_latch_exerciser.sv
// Testbench for latch_exerciser: two instances (SETTLE=7 and SETTLE=1), each
// wired to a behavioural gated D latch; instance A can be given faulty Q/notQ.
module tb_latch_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_a;
  logic start_b;
  int   mode_a;   // 0: good latch, 1: Q stuck at 0, 2: notQ tied to Q

  logic       c_a, d_a, busy_a, done_a, pass_a;
  logic [5:0] mask_a;
  logic [2:0] step_a;
  logic       q_a, nq_a, lq_a;
  logic       held_a = 1'b0;

  logic       c_b, d_b, busy_b, done_b, pass_b;
  logic [5:0] mask_b;
  logic [2:0] step_b;
  logic       q_b, nq_b;
  logic       held_b = 1'b0;

  latch_exerciser #(.SETTLE(7)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .q_in(q_a), .notq_in(nq_a),
    .c_out(c_a), .d_out(d_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_mask(mask_a), .step_idx(step_a)
  );

  latch_exerciser #(.SETTLE(1)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .q_in(q_b), .notq_in(nq_b),
    .c_out(c_b), .d_out(d_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_mask(mask_b), .step_idx(step_b)
  );

  // Behavioural latches: transparent while C is high, otherwise hold the
  // value captured while C was last high (C/D only move on rising edges).
  always @(negedge clk) if (c_a) held_a <= d_a;
  always @(negedge clk) if (c_b) held_b <= d_b;
  assign lq_a = c_a ? d_a : held_a;
  assign q_a  = (mode_a == 1) ? 1'b0 : lq_a;
  assign nq_a = (mode_a == 0) ? ~lq_a : ((mode_a == 1) ? 1'b1 : lq_a);
  assign q_b  = c_b ? d_b : held_b;
  assign nq_b = ~q_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic pass; logic [5:0] mask; } res_t;
  typedef struct { int mode; logic pass; logic [5:0] mask; } vec_t;
  res_t sb_q[$];
  int   done_cycles[$];

  // Expected stimulus, bit i = step i.
  logic [5:0] tc_bits = 6'b010101;
  logic [5:0] td_bits = 6'b000110;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {busy, done, step_idx, c, d} expected t cycles after the accepting edge.
  function automatic logic [6:0] exp_ctl(input int s, input int t);
    int st;
    if (t < 6 * s) begin
      st = t / s;
      return {1'b1, 1'b0, 3'(st), tc_bits[st], td_bits[st]};
    end else if (t == 6 * s) begin
      return 7'b0100000;
    end else begin
      return 7'b0000000;
    end
  endfunction

  // Scoreboard: each done pulse of instance A pops and checks one expected result.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (done_a === 1'b1) begin
      done_cycles.push_back(cyc);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d actual=1 required=0", cyc);
      end else begin
        res_t r;
        r = sb_q.pop_front();
        chk("sb_pass", 32'(pass_a), 32'(r.pass));
        chk("sb_mask", 32'(mask_a), 32'(r.mask));
      end
    end
  end

  // One full run on instance A with cycle-exact control checks.
  task automatic run_a(input int mode, input logic ep, input logic [5:0] em);
    res_t r;
    mode_a = mode;
    r.pass = ep;
    r.mask = em;
    sb_q.push_back(r);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("clr_pass", 32'(pass_a), 32'd0);
    chk("clr_mask", 32'(mask_a), 32'd0);
    for (int t = 0; t <= 6 * 7 + 1; t++) begin
      chk($sformatf("ctl_a_t%0d", t), 32'({busy_a, done_a, step_a, c_a, d_a}), 32'(exp_ctl(7, t)));
      if (t < 6 * 7 + 1) tick();
    end
    repeat (3) tick();
    chk("hold_pass", 32'(pass_a), 32'(ep));
    chk("hold_mask", 32'(mask_a), 32'(em));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    int   k;
    int   n0;
    res_t r;

    vecs[0] = '{mode: 0, pass: 1'b1, mask: 6'b000000};
    vecs[1] = '{mode: 1, pass: 1'b0, mask: 6'b001100};
    vecs[2] = '{mode: 2, pass: 1'b0, mask: 6'b111111};
    vecs[3] = '{mode: 0, pass: 1'b1, mask: 6'b000000};

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; mode_a = 0;
    tick(); tick();
    chk("rst_a", 32'({c_a, d_a, busy_a, done_a, pass_a, mask_a, step_a}), 32'd0);
    chk("rst_b", 32'({c_b, d_b, busy_b, done_b, pass_b, mask_b, step_b}), 32'd0);
    reset = 1'b0;
    tick();

    // Table-driven runs: good latch, stuck Q, tied notQ, good latch again.
    for (int i = 0; i < 4; i++) begin
      run_a(vecs[i].mode, vecs[i].pass, vecs[i].mask);
    end

    // Reset during step 3 with start high: abort, no done, then restart.
    mode_a = 0;
    n0 = done_cycles.size();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (3 * 7) tick();
    chk("pre_rst_step", 32'(step_a), 32'd3);
    reset = 1'b1;
    start_a = 1'b1;
    tick();
    chk("mid_rst", 32'({c_a, d_a, busy_a, done_a, pass_a, mask_a, step_a}), 32'd0);
    reset = 1'b0;
    tick();
    k = cyc;
    start_a = 1'b0;
    chk("start_after_rst", 32'({busy_a, step_a, c_a, d_a}), 32'b100010);
    r.pass = 1'b1;
    r.mask = 6'd0;
    sb_q.push_back(r);
    for (int w = 0; w < 60 && sb_q.size() != 0; w++) tick();
    chk("restart_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("restart_done_cnt", 32'(done_cycles.size()), 32'(n0 + 1));
    chk("restart_done_time", 32'(done_cycles[done_cycles.size() - 1]), 32'(k + 42));
    chk("restart_pass", 32'(pass_a), 32'd1);
    repeat (2) tick();

    // Start held high for 100 edges: runs accepted every 44 cycles only.
    n0 = done_cycles.size();
    r.pass = 1'b1;
    r.mask = 6'd0;
    repeat (3) sb_q.push_back(r);
    start_a = 1'b1;
    tick();
    k = cyc;
    repeat (99) tick();
    start_a = 1'b0;
    for (int w = 0; w < 100 && sb_q.size() != 0; w++) tick();
    repeat (5) tick();
    chk("held_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("held_done_cnt", 32'(done_cycles.size()), 32'(n0 + 3));
    for (int j = 0; j < 3; j++) begin
      if (n0 + j < done_cycles.size()) begin
        chk($sformatf("held_done_time%0d", j), 32'(done_cycles[n0 + j]), 32'(k + 42 + 44 * j));
      end else begin
        chk($sformatf("held_done_missing%0d", j), 32'(done_cycles.size()), 32'(n0 + j + 1));
      end
    end
    chk("held_idle", 32'({busy_a, done_a}), 32'd0);

    // SETTLE=1 instance: one cycle per step, done after edge k+6.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int t = 0; t <= 7; t++) begin
      chk($sformatf("ctl_b_t%0d", t), 32'({busy_b, done_b, step_b, c_b, d_b}), 32'(exp_ctl(1, t)));
      if (t == 6) begin
        chk("b_pass", 32'(pass_b), 32'd1);
        chk("b_mask", 32'(mask_b), 32'd0);
      end
      if (t < 7) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
